// File: rtl/pong_pkg.sv
// Shared types and default timing for the pong match-flow logic.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_FREEZE = 2'd0,
        ST_PLAY   = 2'd1,
        ST_PAUSE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam int unsigned DEF_SERVE_MS    = 2000;
    localparam int unsigned DEF_GAMEOVER_MS = 32767;

    function automatic int unsigned ctr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/match_ctrl_freeze_timer.sv
// Loadable down-counter that can be cut short to its final tick by a skip input.
module freeze_timer #(
    parameter int unsigned CNT_W     = 15,
    parameter int unsigned RESET_VAL = 32767
) (
    input  logic             game_clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             skip_i,
    output logic             zero_o,
    output logic             one_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    // Skip lands on 1 rather than 0 so the final-tick actions still fire exactly once.
    always_ff @(posedge game_clk) begin
        if (reset) begin
            cnt_q <= CNT_W'(RESET_VAL);
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= (skip_i && (cnt_q > ONE)) ? ONE : cnt_q - ONE;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == ONE);

endmodule

// File: rtl/match_ctrl.sv
// Match flow for the pong core: freeze/serve/play/pause sequencing, scoring,
// win detection with a win-by margin, and rally-length speed ramp.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned WIN_BY        = 1,
    parameter int unsigned FREEZE_W      = 15,
    parameter int unsigned SERVE_MS      = DEF_SERVE_MS,
    parameter int unsigned GAMEOVER_MS   = DEF_GAMEOVER_MS,
    parameter int unsigned SPEED_W       = 5,
    parameter int unsigned SPEED_INIT    = 11,
    parameter int unsigned SPEED_MAX     = 15,
    parameter int unsigned HITS_PER_STEP = 4
) (
    input  logic               game_clk,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               out_left,
    input  logic               out_right,
    input  logic               hit,
    output logic [SPEED_W-1:0] speed,
    output logic               ball_reset,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic               paused
);

    localparam int unsigned HIT_W = ctr_width(HITS_PER_STEP);

    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
    localparam logic [SCORE_W-1:0] WIN_SCORE_S = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_BY_S    = SCORE_W'(WIN_BY);
    localparam logic [SPEED_W-1:0] SPEED_INIT_S = SPEED_W'(SPEED_INIT);
    localparam logic [SPEED_W:0]   SPEED_MAX_W  = (SPEED_W+1)'(SPEED_MAX);
    localparam logic [HIT_W-1:0]   HIT_LAST =
        HIT_W'((HITS_PER_STEP == 0) ? 0 : HITS_PER_STEP - 1);

    state_e             state_q;
    winner_e            winner_q;
    logic               match_over_q;
    logic [SCORE_W-1:0] score_p1_q, score_p2_q;
    logic [SPEED_W-1:0] speed_q, saved_speed_q;
    logic [HIT_W-1:0]   hit_cnt_q;
    logic               ball_reset_q;
    logic               paused_q;

    logic [SCORE_W-1:0] score_p1_d, score_p2_d;
    logic [SPEED_W:0]   speed_inc;
    logic [SPEED_W-1:0] speed_ramp_d;
    logic               point_p1, point_p2, point, win;
    logic               frz_zero, frz_one;
    logic [FREEZE_W-1:0] frz_load_val;

    function automatic logic wins(input logic [SCORE_W-1:0] s,
                                  input logic [SCORE_W-1:0] o);
        logic [SCORE_W-1:0] lead;
        lead = (s >= o) ? s - o : '0;
        return ((s >= WIN_SCORE_S) && (lead >= WIN_BY_S)) || (s == SCORE_MAX);
    endfunction

    always_comb begin
        score_p1_d = (score_p1_q == SCORE_MAX) ? score_p1_q : score_p1_q + 1'b1;
        score_p2_d = (score_p2_q == SCORE_MAX) ? score_p2_q : score_p2_q + 1'b1;

        // Left exit beats right exit when both arrive in one cycle.
        point_p1 = (state_q == ST_PLAY) && out_left;
        point_p2 = (state_q == ST_PLAY) && !out_left && out_right;
        point    = point_p1 || point_p2;
        win      = (point_p1 && wins(score_p1_d, score_p2_q)) ||
                   (point_p2 && wins(score_p2_d, score_p1_q));

        frz_load_val = win ? FREEZE_W'(GAMEOVER_MS) : FREEZE_W'(SERVE_MS);

        speed_inc    = {1'b0, speed_q} + 1'b1;
        speed_ramp_d = (speed_inc > SPEED_MAX_W) ? SPEED_MAX_W[SPEED_W-1:0]
                                                 : speed_inc[SPEED_W-1:0];
    end

    freeze_timer #(
        .CNT_W     (FREEZE_W),
        .RESET_VAL (GAMEOVER_MS)
    ) u_freeze (
        .game_clk   (game_clk),
        .reset      (reset),
        .en_i       (state_q == ST_FREEZE),
        .load_i     (point),
        .load_val_i (frz_load_val),
        .skip_i     (start),
        .zero_o     (frz_zero),
        .one_o      (frz_one)
    );

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q       <= ST_FREEZE;
            match_over_q  <= 1'b1;
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            speed_q       <= '0;
            saved_speed_q <= '0;
            hit_cnt_q     <= '0;
            ball_reset_q  <= 1'b1;
            winner_q      <= WIN_NONE;
            paused_q      <= 1'b0;
        end else begin
            ball_reset_q <= (state_q == ST_FREEZE) && frz_one;

            unique case (state_q)
                ST_FREEZE: begin
                    speed_q <= '0;
                    // A finished match is held on screen until the last freeze tick.
                    if (frz_one && match_over_q) begin
                        score_p1_q   <= '0;
                        score_p2_q   <= '0;
                        winner_q     <= WIN_NONE;
                        match_over_q <= 1'b0;
                    end
                    if (frz_zero) begin
                        state_q   <= ST_PLAY;
                        speed_q   <= SPEED_INIT_S;
                        hit_cnt_q <= '0;
                    end
                end

                ST_PLAY: begin
                    if (point) begin
                        if (point_p1) begin
                            score_p1_q <= score_p1_d;
                        end else begin
                            score_p2_q <= score_p2_d;
                        end
                        speed_q   <= '0;
                        state_q   <= ST_FREEZE;
                        hit_cnt_q <= '0;
                        if (win) begin
                            winner_q     <= point_p1 ? WIN_P1 : WIN_P2;
                            match_over_q <= 1'b1;
                        end
                    end else if (pause) begin
                        state_q       <= ST_PAUSE;
                        saved_speed_q <= speed_q;
                        speed_q       <= '0;
                        paused_q      <= 1'b1;
                    end else if (hit && (HITS_PER_STEP != 0)) begin
                        if (hit_cnt_q == HIT_LAST) begin
                            hit_cnt_q <= '0;
                            speed_q   <= speed_ramp_d;
                        end else begin
                            hit_cnt_q <= hit_cnt_q + 1'b1;
                        end
                    end
                end

                ST_PAUSE: begin
                    if (pause) begin
                        state_q  <= ST_PLAY;
                        speed_q  <= saved_speed_q;
                        paused_q <= 1'b0;
                    end
                end

                default: state_q <= ST_FREEZE;
            endcase
        end
    end

    assign speed      = speed_q;
    assign ball_reset = ball_reset_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign winner     = winner_q;
    assign paused     = paused_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: power-up freeze, play-cycle vector table,
// serve/game-over freezes, speed ramp cap, win-by-2 and reset during pause.
module tb_match_ctrl;

    logic       game_clk  = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       pause     = 1'b0;
    logic       out_left  = 1'b0;
    logic       out_right = 1'b0;
    logic       hit       = 1'b0;
    logic [4:0] speed;
    logic       ball_reset;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic       paused;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] in_bits;   // {start, pause, out_left, out_right, hit}
        int         exp_speed;
        int         exp_p1;
        int         exp_p2;
        int         exp_paused;
    } vec_t;

    vec_t tbl[19];

    match_ctrl #(.WIN_BY(2)) dut (
        .game_clk   (game_clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .out_left   (out_left),
        .out_right  (out_right),
        .hit        (hit),
        .speed      (speed),
        .ball_reset (ball_reset),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .winner     (winner),
        .paused     (paused)
    );

    always #5 game_clk = ~game_clk;

    task automatic step();
        @(posedge game_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] b, input int s, input int p1,
                                input int p2, input int pz);
        vec_t v;
        v.in_bits = b; v.exp_speed = s; v.exp_p1 = p1; v.exp_p2 = p2; v.exp_paused = pz;
        return v;
    endfunction

    // One point to the given side, then a start-skipped serve freeze back into PLAY.
    task automatic score_and_serve(input logic left);
        out_left = left; out_right = ~left; step();
        out_left = 1'b0; out_right = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
    endtask

    initial begin
        int n;
        int bad;
        logic got;

        tbl[0]  = mk(5'b00001, 11, 0, 0, 0);
        tbl[1]  = mk(5'b00001, 11, 0, 0, 0);
        tbl[2]  = mk(5'b00001, 11, 0, 0, 0);
        tbl[3]  = mk(5'b00001, 12, 0, 0, 0);
        tbl[4]  = mk(5'b00000, 12, 0, 0, 0);
        tbl[5]  = mk(5'b00001, 12, 0, 0, 0);
        tbl[6]  = mk(5'b00001, 12, 0, 0, 0);
        tbl[7]  = mk(5'b00001, 12, 0, 0, 0);
        tbl[8]  = mk(5'b00001, 13, 0, 0, 0);
        tbl[9]  = mk(5'b01001,  0, 0, 0, 1);
        tbl[10] = mk(5'b00100,  0, 0, 0, 1);
        tbl[11] = mk(5'b00001,  0, 0, 0, 1);
        tbl[12] = mk(5'b10000,  0, 0, 0, 1);
        tbl[13] = mk(5'b01000, 13, 0, 0, 0);
        tbl[14] = mk(5'b00001, 13, 0, 0, 0);
        tbl[15] = mk(5'b00001, 13, 0, 0, 0);
        tbl[16] = mk(5'b00001, 13, 0, 0, 0);
        tbl[17] = mk(5'b00001, 14, 0, 0, 0);
        tbl[18] = mk(5'b00111,  0, 1, 0, 0);

        // Reset state
        step(); step();
        check("rst_speed", int'(speed), 0);
        check("rst_ball_reset", int'(ball_reset), 1);
        check("rst_p1", int'(score_p1), 0);
        check("rst_p2", int'(score_p2), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_paused", int'(paused), 0);
        reset = 1'b0;

        // Power-up game-over freeze, no start
        bad = 0;
        for (int i = 1; i <= 32768; i++) begin
            step();
            if (i < 32767) begin
                if (speed != 5'd0 || ball_reset) bad++;
            end else if (i == 32767) begin
                check("pwr_ball_reset_32767", int'(ball_reset), 1);
                check("pwr_speed_32767", int'(speed), 0);
            end else begin
                check("pwr_speed_32768", int'(speed), 11);
                check("pwr_ball_reset_32768", int'(ball_reset), 0);
            end
        end
        check("pwr_freeze_quiet", bad, 0);

        // Play-cycle vectors
        for (int i = 0; i < 19; i++) begin
            {start, pause, out_left, out_right, hit} = tbl[i].in_bits;
            step();
            {start, pause, out_left, out_right, hit} = 5'b00000;
            check($sformatf("vec%0d_speed", i), int'(speed), tbl[i].exp_speed);
            check($sformatf("vec%0d_p1", i), int'(score_p1), tbl[i].exp_p1);
            check($sformatf("vec%0d_p2", i), int'(score_p2), tbl[i].exp_p2);
            check($sformatf("vec%0d_paused", i), int'(paused), tbl[i].exp_paused);
        end

        // Serve freeze length; an out during freeze is ignored
        n = 0; got = 1'b0;
        while (n < 2100 && !got) begin
            out_right = (n == 4); step(); out_right = 1'b0; n++;
            if (ball_reset) got = 1'b1;
        end
        check("serve_freeze_len", n, 2000);
        check("serve_freeze_p1", int'(score_p1), 1);
        check("serve_freeze_p2", int'(score_p2), 0);
        step();
        check("serve_speed", int'(speed), 11);
        check("serve_ball_reset_low", int'(ball_reset), 0);

        // Speed ramp and cap
        for (int i = 1; i <= 28; i++) begin
            hit = 1'b1; step(); hit = 1'b0;
            if (i == 8) check("ramp_8_hits", int'(speed), 13);
        end
        check("ramp_cap", int'(speed), 15);

        // Point, then start cuts freeze short; serve speed back to 11
        out_right = 1'b1; step(); out_right = 1'b0;
        check("p2_point", int'(score_p2), 1);
        check("p2_point_speed", int'(speed), 0);
        start = 1'b1; step(); start = 1'b0;
        check("skip_no_pulse_yet", int'(ball_reset), 0);
        step();
        check("skip_ball_reset", int'(ball_reset), 1);
        check("skip_speed_frozen", int'(speed), 0);
        step();
        check("skip_serve_speed", int'(speed), 11);
        check("skip_ball_reset_low", int'(ball_reset), 0);

        // Win-by-2: bring to 8:8
        for (int i = 0; i < 7; i++) begin
            score_and_serve(1'b1);
            score_and_serve(1'b0);
        end
        check("tie_p1", int'(score_p1), 8);
        check("tie_p2", int'(score_p2), 8);

        out_left = 1'b1; step(); out_left = 1'b0;
        check("nine_eight_p1", int'(score_p1), 9);
        check("nine_eight_winner", int'(winner), 0);
        n = 0; got = 1'b0;
        while (n < 2100 && !got) begin
            step(); n++;
            if (ball_reset) got = 1'b1;
        end
        check("nine_eight_serve_len", n, 2000);
        step();
        check("nine_eight_serve_speed", int'(speed), 11);

        out_left = 1'b1; step(); out_left = 1'b0;
        check("win_p1", int'(score_p1), 10);
        check("win_p2", int'(score_p2), 8);
        check("win_winner", int'(winner), 1);
        check("win_speed", int'(speed), 0);
        n = 0; got = 1'b0;
        while (n < 33000 && !got) begin
            step(); n++;
            if (n == 32766) begin
                check("gameover_hold_p1", int'(score_p1), 10);
                check("gameover_hold_winner", int'(winner), 1);
            end
            if (ball_reset) got = 1'b1;
        end
        check("gameover_freeze_len", n, 32767);
        check("gameover_clear_p1", int'(score_p1), 0);
        check("gameover_clear_p2", int'(score_p2), 0);
        check("gameover_clear_winner", int'(winner), 0);
        step();
        check("new_match_speed", int'(speed), 11);

        // Reset while paused at 5:3
        score_and_serve(1'b1); score_and_serve(1'b0);
        score_and_serve(1'b1); score_and_serve(1'b0);
        score_and_serve(1'b1); score_and_serve(1'b0);
        score_and_serve(1'b1); score_and_serve(1'b1);
        check("pre_reset_p1", int'(score_p1), 5);
        check("pre_reset_p2", int'(score_p2), 3);
        pause = 1'b1; step(); pause = 1'b0;
        check("pre_reset_paused", int'(paused), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid_rst_p1", int'(score_p1), 0);
        check("mid_rst_p2", int'(score_p2), 0);
        check("mid_rst_speed", int'(speed), 0);
        check("mid_rst_winner", int'(winner), 0);
        check("mid_rst_ball_reset", int'(ball_reset), 1);
        check("mid_rst_paused", int'(paused), 0);
        step();
        check("mid_rst_ball_reset_drop", int'(ball_reset), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
